// File: rtl/lsu_pkg.sv
// Shared funct3/cause constants, FSM encoding and decode helpers for the load/store controller.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_CAPTURE,
    S_WR_ISSUE,
    S_RESP
  } lsu_state_t;

  // Bytes touched by an access; illegal codes are filtered before this matters.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: access_size = 3'd1;
      F3_H, F3_HU: access_size = 3'd2;
      default:     access_size = 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic [2:0] funct3, input logic we);
    case (funct3)
      F3_B, F3_H, F3_W: funct3_legal = 1'b1;
      F3_BU, F3_HU:     funct3_legal = !we;
      default:          funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load extraction/extension and byte/halfword store merge; the addressed byte is the word MSB.
import lsu_pkg::*;

module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  always_comb begin
    load_data  = old_word;
    store_word = wdata;
    case (funct3)
      F3_B: begin
        load_data  = {{24{old_word[31]}}, old_word[31:24]};
        store_word = {wdata[7:0], old_word[23:0]};
      end
      F3_H: begin
        load_data  = {{16{old_word[31]}}, old_word[31:16]};
        store_word = {wdata[15:0], old_word[15:0]};
      end
      F3_BU:   load_data = {24'd0, old_word[31:24]};
      F3_HU:   load_data = {16'd0, old_word[31:16]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller driving a registered-read RAM; sub-word stores use read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN makes misaligned H/HU/W accesses fault with cause 01.
import lsu_pkg::*;

module lsu_mem_ctrl #(
  parameter int ADDR_BITS     = 11,
  parameter int BANK_OFS_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  resp_cause,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_write_en,
  input  logic [31:0] mem_dout,
  input  logic [7:0]  mem_seg_faults
);

  localparam logic [BANK_OFS_BITS:0] BANK_BYTES = {1'b1, {BANK_OFS_BITS{1'b0}}};

  lsu_state_t state;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_wdata;

  logic [2:0]             req_size;
  logic [BANK_OFS_BITS:0] end_ofs;
  logic                   illegal;
  logic                   misaligned;
  logic                   out_of_range;
  logic [1:0]             req_cause;
  logic [31:0]            load_data;
  logic [31:0]            store_word;
  logic                   seg_fault;

  // Classify the incoming request; illegal beats misaligned beats range.
  always_comb begin
    req_size = access_size(req_funct3);
    end_ofs  = {1'b0, req_addr[BANK_OFS_BITS-1:0]} + (BANK_OFS_BITS+1)'(req_size);
    illegal  = !funct3_legal(req_funct3, req_we);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (req_size == 3'd2 && req_addr[0]) ||
                 (req_size == 3'd4 && req_addr[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
    out_of_range = (|req_addr[31:ADDR_BITS]) || (end_ofs > BANK_BYTES);
    if (illegal)
      req_cause = CAUSE_ILLEGAL;
    else if (misaligned)
      req_cause = CAUSE_MISALIGN;
    else if (out_of_range)
      req_cause = CAUSE_RANGE;
    else
      req_cause = CAUSE_NONE;
  end

  lsu_align u_align (
    .funct3     (lat_f3),
    .old_word   (mem_dout),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // mem_addr still holds the store address while in WR_ISSUE.
  assign seg_fault = mem_seg_faults[mem_addr[ADDR_BITS-1:BANK_OFS_BITS]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_fault   <= 1'b0;
      resp_cause   <= CAUSE_NONE;
      mem_addr     <= '0;
      mem_din      <= '0;
      mem_write_en <= 1'b0;
      lat_we       <= 1'b0;
      lat_f3       <= F3_B;
      lat_wdata    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_f3    <= req_funct3;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (req_cause != CAUSE_NONE) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_fault <= 1'b1;
              resp_cause <= req_cause;
            end else if (!req_we || req_funct3 != F3_W) begin
              state    <= S_RD_ISSUE;
              mem_addr <= req_addr;
            end else begin
              state        <= S_WR_ISSUE;
              mem_addr     <= req_addr;
              mem_din      <= req_wdata;
              mem_write_en <= 1'b1;
            end
          end
        end
        S_RD_ISSUE: state <= S_RD_CAPTURE;
        S_RD_CAPTURE: begin
          if (lat_we) begin
            state        <= S_WR_ISSUE;
            mem_din      <= store_word;
            mem_write_en <= 1'b1;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
            resp_fault <= 1'b0;
            resp_cause <= CAUSE_NONE;
          end
        end
        S_WR_ISSUE: begin
          state        <= S_RESP;
          mem_write_en <= 1'b0;
          resp_valid   <= 1'b1;
          resp_rdata   <= '0;
          resp_fault   <= seg_fault;
          resp_cause   <= seg_fault ? CAUSE_RANGE : CAUSE_NONE;
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= S_IDLE;
          req_ready    <= 1'b1;
          resp_valid   <= 1'b0;
          mem_write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: byte-level memory model, directed cases, then random traffic.
import lsu_pkg::*;

module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_write_en;
  logic [31:0] mem_dout = '0;
  logic [7:0]  mem_seg_faults = '0;

  int total = 0;
  int bad = 0;
  int wrCount = 0;
  logic [31:0] lastRdata;
  logic [31:0] lastExpRd;

  logic [7:0] ram    [0:2047];
  logic [7:0] refMem [0:2047];

  lsu_mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .resp_cause     (resp_cause),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_write_en   (mem_write_en),
    .mem_dout       (mem_dout),
    .mem_seg_faults (mem_seg_faults)
  );

  always #5 clk = ~clk;

  // Byte-addressed RAM with registered read; the addressed byte is the word MSB.
  always @(posedge clk) begin
    if (mem_write_en)
      for (int i = 0; i < 4; i++)
        ram[11'(mem_addr + 32'(i))] <= mem_din[31-8*i -: 8];
    mem_dout <= {ram[11'(mem_addr)], ram[11'(mem_addr + 32'd1)],
                 ram[11'(mem_addr + 32'd2)], ram[11'(mem_addr + 32'd3)]};
  end

  always @(negedge clk)
    if (mem_write_en) wrCount <= wrCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Reference behaviour from the access rules, operating on a plain byte array.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [7:0] seg,
                       output bit f, output logic [1:0] c, output logic [31:0] rd,
                       output int lat, output int nw);
    int sz;
    bit legal;
    logic [31:0] raw;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    f = 1'b0; c = 2'd0; rd = '0; lat = 1; nw = 0;
    if (!legal) begin
      f = 1'b1; c = 2'd3; return;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % sz) != 0) begin
      f = 1'b1; c = 2'd1; return;
    end
`endif
    if (a >= 32'd2048 || (int'(a % 256) + sz) > 256) begin
      f = 1'b1; c = 2'd2; return;
    end
    if (we) begin
      for (int i = 0; i < sz; i++) refMem[int'(a) + i] = wd[8*(sz-1-i) +: 8];
      nw = 1;
      lat = (sz == 4) ? 2 : 4;
      f = seg[a[10:8]];
      c = f ? 2'd2 : 2'd0;
    end else begin
      raw = '0;
      for (int i = 0; i < sz; i++) raw = (raw << 8) | 32'(refMem[int'(a) + i]);
      if (!f3[2] && sz < 4 && raw[8*sz-1]) raw = raw | ~((32'd1 << (8*sz)) - 32'd1);
      rd = raw;
      lat = 3;
    end
  endtask

  // One full transaction; every cycle until the handshake is checked against the model.
  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [7:0] seg, input int hold);
    bit ef;
    logic [1:0] ec;
    logic [31:0] er;
    int el, ew, lat, w0;
    model(we, f3, a, wd, seg, ef, ec, er, el, ew);
    lastExpRd = er;
    checkOutput("idle_ready", 32'(req_ready), 32'd1);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_seg_faults = seg; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk);
    w0 = wrCount;
    #1 req_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      checkOutput("busy_ready", 32'(req_ready), 32'd0);
      if (resp_valid || lat >= 16) break;
      @(posedge clk);
    end
    checkOutput("resp_seen", 32'(resp_valid), 32'd1);
    checkOutput("latency", 32'(lat), 32'(el));
    checkOutput("fault", 32'(resp_fault), 32'(ef));
    checkOutput("cause", 32'(resp_cause), 32'(ec));
    checkOutput("rdata", resp_rdata, er);
    lastRdata = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall_valid", 32'(resp_valid), 32'd1);
      checkOutput("stall_rdata", resp_rdata, er);
      checkOutput("stall_cause", 32'(resp_cause), 32'(ec));
      checkOutput("stall_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    checkOutput("write_pulses", 32'(wrCount - w0), 32'(ew));
  endtask

  initial begin
    logic [31:0] oldVal;
    logic [2:0]  f3List [0:4];
    logic [31:0] a;
    logic [2:0]  f3;
    f3List[0] = F3_B; f3List[1] = F3_H; f3List[2] = F3_W; f3List[3] = F3_BU; f3List[4] = F3_HU;
    for (int i = 0; i < 2048; i++) begin
      ram[i]    = 8'(i * 7 + 3);
      refMem[i] = 8'(i * 7 + 3);
    end

    #12;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_fault", 32'(resp_fault), 32'd0);
    checkOutput("rst_resp_cause", 32'(resp_cause), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_din", mem_din, 32'd0);
    checkOutput("rst_mem_we", 32'(mem_write_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, F3_W, 32'h010, 32'hDEADBEEF, 8'h00, 0);
    applyStimulus(1'b0, F3_W, 32'h010, 32'h0, 8'h00, 0);
    checkOutput("lw_010_lit", lastRdata, 32'hDEADBEEF);

    applyStimulus(1'b1, F3_B, 32'h011, 32'h000000A5, 8'h00, 0);
    applyStimulus(1'b0, F3_BU, 32'h011, 32'h0, 8'h00, 0);
    checkOutput("lbu_011_lit", lastRdata, 32'h000000A5);
    applyStimulus(1'b0, F3_B, 32'h011, 32'h0, 8'h00, 0);
    checkOutput("lb_011_lit", lastRdata, 32'hFFFFFFA5);
    applyStimulus(1'b0, F3_W, 32'h010, 32'h0, 8'h00, 0);
    checkOutput("lw_merge_lit", lastRdata, 32'hDEA5BEEF);

    applyStimulus(1'b1, F3_H, 32'h102, 32'h00008001, 8'h00, 0);
    applyStimulus(1'b0, F3_H, 32'h102, 32'h0, 8'h00, 0);
    checkOutput("lh_102_lit", lastRdata, 32'hFFFF8001);
    applyStimulus(1'b0, F3_HU, 32'h102, 32'h0, 8'h00, 0);
    checkOutput("lhu_102_lit", lastRdata, 32'h00008001);
    applyStimulus(1'b0, F3_W, 32'h002, 32'h0, 8'h00, 0);
    checkOutput("lw_002_lit", lastRdata, 32'h11181F26);

    applyStimulus(1'b0, F3_W, 32'h0FE, 32'h0, 8'h00, 0);
    checkOutput("bank_cross_cause", 32'(resp_cause), 32'd2);
    applyStimulus(1'b0, F3_W, 32'h00000800, 32'h0, 8'h00, 0);
    checkOutput("range_cause", 32'(resp_cause), 32'd2);
    applyStimulus(1'b0, 3'b011, 32'h010, 32'h0, 8'h00, 0);
    checkOutput("illegal_f3_cause", 32'(resp_cause), 32'd3);
    applyStimulus(1'b1, F3_BU, 32'h010, 32'h1, 8'h00, 0);
    checkOutput("store_bu_cause", 32'(resp_cause), 32'd3);
    applyStimulus(1'b0, F3_H, 32'h003, 32'h0, 8'h00, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("lh_003_cause", 32'(resp_cause), 32'd1);
`else
    checkOutput("lh_003_data", lastRdata, 32'h0000181F);
`endif
    applyStimulus(1'b1, F3_W, 32'h310, 32'h01020304, 8'h08, 0);
    checkOutput("seg_fault_cause", 32'(resp_cause), 32'd2);

    applyStimulus(1'b0, F3_W, 32'h010, 32'h0, 8'h00, 5);

    applyStimulus(1'b0, F3_W, 32'h020, 32'h0, 8'h00, 0);
    oldVal = lastExpRd;
    req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h020; req_wdata = 32'h12345678;
    mem_seg_faults = 8'h00; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("wr_issue_strobe", 32'(mem_write_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_we_drop", 32'(mem_write_en), 32'd0);
    checkOutput("async_ready", 32'(req_ready), 32'd1);
    checkOutput("async_resp_valid", 32'(resp_valid), 32'd0);
    #1 rst = 1'b0;
    applyStimulus(1'b0, F3_W, 32'h020, 32'h0, 8'h00, 0);
    checkOutput("lw_020_unchanged", lastRdata, oldVal);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'h800 | 32'($urandom_range(0, 255));
        2:       a = (32'($urandom_range(0, 7)) << 8) | 32'($urandom_range(250, 255));
        default: begin
          a = 32'($urandom_range(0, 2047));
          if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
        end
      endcase
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : f3List[$urandom_range(0, 4)];
      applyStimulus(1'($urandom), f3, a, $urandom,
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                    int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
